pipe_scheduler: RTL and testbench
=================================

# pipe_scheduler

Frame-synchronous obstacle controller feeding the pipe inputs of `game_render_controller`. It owns the three pipe positions and scrolls them once per video frame. When a pipe leaves the screen on the left, it is recycled to the right with a fresh pseudo-random gap height. It also counts pipes passed by the bird, and that count drives the renderer's score input.

## Interface
- `SCREEN_WIDTH`, 640: visible width in pixels.
- `PIPE_WIDTH`, 52: pipe sprite width.
- `PIPE_SPACING`, 240: horizontal distance between consecutive pipes. Must satisfy 3*PIPE_SPACING − PIPE_WIDTH − 1 ≥ SCREEN_WIDTH.
- `SCROLL_STEP`, 2: pixels moved per frame tick.
- `GAP_MIN`, 40: minimum gap-top Y. The maximum is GAP_MIN+255, which must be < 380.
- `BIRD_LEFT_X`, 303: bird sprite left edge, equal to 320 − 34/2.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be nonzero.
- `iClock` in 1: system clock.
- `iReset` in 1: synchronous, active-high reset.
- `iFrameTick` in 1: one-cycle pulse per frame, asserted when the pixel address is 0.
- `iStart` in 1: one-cycle pulse; starts or restarts a run.
- `iCollide` in 1: level; bird hit detected.
- `oPipe1X`, `oPipe2X`, `oPipe3X` out signed 17: left edge of each pipe.
- `oPipe1Y`, `oPipe2Y`, `oPipe3Y` out signed 17: top of each pipe's gap.
- `oScore` out 16: pipes passed; saturates at 16'hFFFF.
- `oScorePulse` out 1: one-cycle pulse per score increment.
- `oRunning` out 1: high in RUN.

## Operation
- **States:**
  - IDLE: pipes parked.
  - RUN: scrolling.
  - FROZEN: positions held after a collision.
- **Transitions:**
  - IDLE→RUN on iStart.
  - RUN→FROZEN on iCollide.
  - FROZEN→RUN on iStart.
  - iStart in RUN is ignored.
  - iCollide outside RUN is ignored.
- **Park position:** PARK_X = −PIPE_WIDTH−1 = −53, with Y = 0. The renderer treats this as invalid, so parked pipes are not drawn.
- **Run entry (from IDLE or FROZEN):**
  - Pipe k (k = 0..2) gets X = SCREEN_WIDTH + k*PIPE_SPACING, i.e. 640 / 880 / 1120.
  - Y values are GAP_MIN+lfsr[7:0], GAP_MIN+lfsr[15:8] and GAP_MIN+(lfsr[7:0]^lfsr[15:8]), sampled in the entry cycle.
  - oScore is cleared.
- **Frame tick in RUN, applied to each pipe independently:**
  - nx = X − SCROLL_STEP.
  - If nx < −PIPE_WIDTH, then X = nx + 3*PIPE_SPACING and Y = GAP_MIN + lfsr[7:0]. Otherwise X = nx.
- **Score:** a pipe scores on the tick where X+PIPE_WIDTH ≥ BIRD_LEFT_X before the move and < BIRD_LEFT_X after it.
  - oScore increases by the number of pipes that scored, saturating.
  - oScorePulse is high if any pipe scored.
- **LFSR:** 16-bit Galois, polynomial mask 16'hB400, shifting every clock in all states. It never reaches zero.
  - If two pipes recycle on the same tick, pipe n uses lfsr[7:0] rotated left by n bits.
- **Width rule:** all X/Y arithmetic is signed 17-bit, with no wrap in the legal range.

## Timing
- All outputs are registered.
- An update caused by iFrameTick, iStart or iCollide at edge N is visible after edge N. oScorePulse is high for exactly the cycle after edge N.
- Reset values:
  - State IDLE.
  - All X = −53, all Y = 0.
  - oScore = 0, oScorePulse = 0, oRunning = 0.
  - lfsr = LFSR_SEED.
- Reset has priority over everything, including mid-run: the next cycle shows IDLE values.
- If iFrameTick and iCollide coincide in RUN, the collision wins: the state goes to FROZEN with no move and no score.
- If iStart and iFrameTick coincide on a transition into RUN, the re-init wins with no move.
- Outputs change only on frame ticks or state transitions, so the renderer sees stable values for a whole frame.

## Structure
- Shared package `game_pkg` holds:
  - SCREEN_WIDTH, SCREEN_HEIGHT, PIPE_WIDTH, PIPE_HEIGHT, PIPE_GAP_HEIGHT, BIRD_WIDTH.
  - The state enum {IDLE, RUN, FROZEN}.
  - The pipe-coordinate type (signed 17).
- Sub-module `lfsr16` (inputs clock, reset, seed; output value) is reused later by game logic.
- Per-pipe update logic is one generate loop over three identical lanes.

## Test plan
- **Reset and idle:** assert reset, then release with 100 ticks and no iStart → all X = −53, Y = 0, oScore = 0, oRunning = 0 throughout.
- **Start and scroll:** iStart, then one tick → X = 640/880/1120, then 638/878/1118. Each Y is in [40, 295] and matches an LFSR reference model.
- **Recycle:** run until pipe 1 X = −52; the next tick → X = −54+720 = 666 with a new Y from the model, and pipes 2 and 3 are unaffected.
- **Score:** pipe with X = 252 (X+52 = 304), then one tick → X = 250, oScore 0→1, oScorePulse high for exactly 1 cycle. No pulse on the following tick.
- **Collision and restart:** iCollide coincident with iFrameTick → no move, state FROZEN, positions held over 10 ticks. Then iStart → re-init to 640/880/1120 and oScore = 0.
- **Reset mid-run:** after oScore = 5, assert iReset for one cycle → the next cycle shows IDLE reset values, and the LFSR restarts at the seed.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants, FSM state encoding and pipe coordinate type.
// Latency: n/a (package only).
// Backpressure: n/a.
package game_pkg;

  localparam int SCREEN_WIDTH    = 640;
  localparam int SCREEN_HEIGHT   = 480;
  localparam int PIPE_WIDTH      = 52;
  localparam int PIPE_HEIGHT     = 320;
  localparam int PIPE_GAP_HEIGHT = 100;
  localparam int BIRD_WIDTH      = 34;
  localparam int NUM_PIPES       = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  typedef logic signed [16:0] pipe_coord_t;

  // Rotate a byte left by n; used to decorrelate simultaneous recycles.
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    logic [15:0] d;
    d = {v, v} << (n % 8);
    return d[15:8];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR (mask 16'hB400), advances every clock, reloads seed on reset.
// Latency: value updates one cycle after each edge.
// Backpressure: none, free-running.
module lfsr16 (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iSeed,
  output logic [15:0] oValue
);

  localparam logic [15:0] TAPS = 16'hB400;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      oValue <= iSeed;
    end else begin
      oValue <= {1'b0, oValue[15:1]} ^ (oValue[0] ? TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/pipe_scheduler.sv
// Frame-synchronous owner of three scrolling pipes, recycling and score counting.
// Latency: all outputs registered, visible the cycle after the causing edge.
// Backpressure: none; frame ticks are consumed unconditionally in RUN.
module pipe_scheduler #(
  parameter int          SCREEN_WIDTH = 640,
  parameter int          PIPE_WIDTH   = 52,
  parameter int          PIPE_SPACING = 240,
  parameter int          SCROLL_STEP  = 2,
  parameter int          GAP_MIN      = 40,
  parameter int          BIRD_LEFT_X  = 303,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iFrameTick,
  input  logic                 iStart,
  input  logic                 iCollide,
  output game_pkg::pipe_coord_t oPipe1X,
  output game_pkg::pipe_coord_t oPipe2X,
  output game_pkg::pipe_coord_t oPipe3X,
  output game_pkg::pipe_coord_t oPipe1Y,
  output game_pkg::pipe_coord_t oPipe2Y,
  output game_pkg::pipe_coord_t oPipe3Y,
  output logic [15:0]          oScore,
  output logic                 oScorePulse,
  output logic                 oRunning
);

  localparam game_pkg::pipe_coord_t PARK_X = 17'(-PIPE_WIDTH - 1);
  localparam game_pkg::pipe_coord_t STEP   = 17'(SCROLL_STEP);
  localparam game_pkg::pipe_coord_t PW     = 17'(PIPE_WIDTH);
  localparam game_pkg::pipe_coord_t NEG_PW = 17'(-PIPE_WIDTH);
  localparam game_pkg::pipe_coord_t SPAN   = 17'(3 * PIPE_SPACING);
  localparam game_pkg::pipe_coord_t BIRD_X = 17'(BIRD_LEFT_X);
  localparam game_pkg::pipe_coord_t GAP_Y0 = 17'(GAP_MIN);

  game_pkg::state_t state, next_state;
  logic             do_init, do_step;
  logic [15:0]      lfsr;
  logic [2:0]       recycle, scored;
  logic             multi_recycle;
  logic [16:0]      score_sum;

  lfsr16 u_lfsr (
    .iClock (iClock),
    .iReset (iReset),
    .iSeed  (LFSR_SEED),
    .oValue (lfsr)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= game_pkg::IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      game_pkg::IDLE:   if (iStart)   next_state = game_pkg::RUN;
      game_pkg::RUN:    if (iCollide) next_state = game_pkg::FROZEN;
      game_pkg::FROZEN: if (iStart)   next_state = game_pkg::RUN;
      default:                        next_state = game_pkg::IDLE;
    endcase
  end

  // A collision on the same edge as a tick suppresses the move.
  always_comb begin
    do_init  = iStart && (state != game_pkg::RUN);
    do_step  = (state == game_pkg::RUN) && iFrameTick && !iCollide;
    oRunning = (state == game_pkg::RUN);
  end

  assign multi_recycle = $countones(recycle) > 1;

  for (genvar k = 0; k < 3; k++) begin : g_lane
    game_pkg::pipe_coord_t x_q, y_q, nx;
    logic [7:0]            init_b, recyc_b;

    if (k == 0) begin : g_b0
      assign init_b = lfsr[7:0];
    end else if (k == 1) begin : g_b1
      assign init_b = lfsr[15:8];
    end else begin : g_b2
      assign init_b = lfsr[7:0] ^ lfsr[15:8];
    end

    assign nx         = x_q - STEP;
    assign recycle[k] = nx < NEG_PW;
    assign scored[k]  = ((x_q + PW) >= BIRD_X) && ((nx + PW) < BIRD_X);
    assign recyc_b    = multi_recycle ? game_pkg::rotl8(lfsr[7:0], k) : lfsr[7:0];

    always_ff @(posedge iClock) begin
      if (iReset) begin
        x_q <= PARK_X;
        y_q <= '0;
      end else if (do_init) begin
        x_q <= 17'(SCREEN_WIDTH + k * PIPE_SPACING);
        y_q <= GAP_Y0 + {9'd0, init_b};
      end else if (do_step) begin
        if (recycle[k]) begin
          x_q <= nx + SPAN;
          y_q <= GAP_Y0 + {9'd0, recyc_b};
        end else begin
          x_q <= nx;
        end
      end
    end
  end

  assign oPipe1X = g_lane[0].x_q;
  assign oPipe2X = g_lane[1].x_q;
  assign oPipe3X = g_lane[2].x_q;
  assign oPipe1Y = g_lane[0].y_q;
  assign oPipe2Y = g_lane[1].y_q;
  assign oPipe3Y = g_lane[2].y_q;

  assign score_sum = {1'b0, oScore} + 17'($countones(scored));

  always_ff @(posedge iClock) begin
    if (iReset) begin
      oScore      <= '0;
      oScorePulse <= 1'b0;
    end else begin
      oScorePulse <= 1'b0;
      if (do_init) begin
        oScore <= '0;
      end else if (do_step && (|scored)) begin
        oScorePulse <= 1'b1;
        oScore      <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler with a small pipe/LFSR reference model.
module tb_pipe_scheduler;

  logic iClock = 1'b0;
  logic iReset, iFrameTick, iStart, iCollide;
  logic signed [16:0] oPipe1X, oPipe2X, oPipe3X, oPipe1Y, oPipe2Y, oPipe3Y;
  logic [15:0] oScore;
  logic oScorePulse, oRunning;

  pipe_scheduler u_dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iFrameTick  (iFrameTick),
    .iStart      (iStart),
    .iCollide    (iCollide),
    .oPipe1X     (oPipe1X),
    .oPipe2X     (oPipe2X),
    .oPipe3X     (oPipe3X),
    .oPipe1Y     (oPipe1Y),
    .oPipe2Y     (oPipe2Y),
    .oPipe3Y     (oPipe3Y),
    .oScore      (oScore),
    .oScorePulse (oScorePulse),
    .oRunning    (oRunning)
  );

  always #5 iClock = ~iClock;

  int vectors = 0;
  int miscompares = 0;

  logic signed [16:0] px [3];
  logic signed [16:0] py [3];
  assign px[0] = oPipe1X;
  assign px[1] = oPipe2X;
  assign px[2] = oPipe3X;
  assign py[0] = oPipe1Y;
  assign py[1] = oPipe2Y;
  assign py[2] = oPipe3Y;

  // Reference LFSR, sampled just before each edge to predict what the DUT latches.
  logic [15:0] m_lfsr;
  always @(posedge iClock) begin
    if (iReset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  int   ex [3];
  int   ey [3];
  int   escore;
  logic mrun;
  logic last_pulse;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_x%0d", tag, k), px[k], ex[k]);
      check($sformatf("%s_y%0d", tag, k), py[k], ey[k]);
    end
    check($sformatf("%s_score", tag), oScore, escore);
    check($sformatf("%s_running", tag), oRunning, mrun);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      ex[k] = -53;
      ey[k] = 0;
    end
    escore = 0;
    mrun   = 1'b0;
  endtask

  task automatic frame();
    int nx;
    int cnt;
    cnt = 0;
    if (mrun) begin
      for (int k = 0; k < 3; k++) begin
        nx = ex[k] - 2;
        if (ex[k] + 52 >= 303 && nx + 52 < 303) cnt++;
        if (nx < -52) begin
          ex[k] = nx + 720;
          ey[k] = 40 + int'(m_lfsr[7:0]);
        end else begin
          ex[k] = nx;
        end
      end
      escore = (escore + cnt > 65535) ? 65535 : escore + cnt;
    end
    iFrameTick = 1'b1;
    @(posedge iClock); #1;
    iFrameTick = 1'b0;
    last_pulse = oScorePulse;
    check("tick_pulse", oScorePulse, (cnt > 0));
    @(posedge iClock); #1;
    check("pulse_drop", oScorePulse, 0);
    check_state("frame");
  endtask

  task automatic start(input logic with_tick);
    ex[0] = 640;
    ex[1] = 880;
    ex[2] = 1120;
    ey[0] = 40 + int'(m_lfsr[7:0]);
    ey[1] = 40 + int'(m_lfsr[15:8]);
    ey[2] = 40 + int'(m_lfsr[7:0] ^ m_lfsr[15:8]);
    escore = 0;
    mrun   = 1'b1;
    iStart     = 1'b1;
    iFrameTick = with_tick;
    @(posedge iClock); #1;
    iStart     = 1'b0;
    iFrameTick = 1'b0;
    check("start_pulse", oScorePulse, 0);
    check_state("start");
  endtask

  initial begin
    int n;
    int old1, old2;
    iReset = 1'b1; iFrameTick = 1'b0; iStart = 1'b0; iCollide = 1'b0;
    model_reset();
    @(posedge iClock); @(posedge iClock); #1;
    iReset = 1'b0;
    check_state("reset");
    check("reset_pulse", oScorePulse, 0);
    check("reset_lfsr", u_dut.u_lfsr.oValue, 16'hACE1);
    @(posedge iClock); #1;
    check("lfsr_step1", u_dut.u_lfsr.oValue, 16'hE270);

    // Idle: ticks and a stray collision do nothing.
    for (int i = 0; i < 100; i++) frame();
    iCollide = 1'b1;
    @(posedge iClock); #1;
    iCollide = 1'b0;
    check_state("idle_collide");

    // Start coincident with a tick: re-init wins, no move.
    start(1'b1);
    check("start_x0", oPipe1X, 640);
    check("start_x1", oPipe2X, 880);
    check("start_x2", oPipe3X, 1120);
    for (int k = 0; k < 3; k++) check($sformatf("start_yrange%0d", k), (py[k] >= 40 && py[k] <= 295), 1);
    frame();
    check("scroll_x0", oPipe1X, 638);
    check("scroll_x1", oPipe2X, 878);
    check("scroll_x2", oPipe3X, 1118);

    // Score crossing at X=252 -> 250.
    n = 0;
    while (ex[0] != 252 && n < 400) begin frame(); n++; end
    check("reach_252", oPipe1X, 252);
    check("pre_score", oScore, 0);
    frame();
    check("score_x0", oPipe1X, 250);
    check("score_one", oScore, 1);
    check("score_pulse", last_pulse, 1);
    frame();
    check("no_pulse_next", last_pulse, 0);
    check("score_hold", oScore, 1);

    // Recycle of pipe 1 from -52.
    n = 0;
    while (ex[0] != -52 && n < 400) begin frame(); n++; end
    check("reach_m52", oPipe1X, -52);
    old1 = int'(oPipe2X);
    old2 = int'(oPipe3X);
    frame();
    check("recycle_x0", oPipe1X, 666);
    check("recycle_x1", oPipe2X, old1 - 2);
    check("recycle_x2", oPipe3X, old2 - 2);
    check("recycle_yrange", (oPipe1Y >= 40 && oPipe1Y <= 295), 1);

    // Collision on a tick: no move, frozen.
    mrun = 1'b0;
    iCollide = 1'b1; iFrameTick = 1'b1;
    @(posedge iClock); #1;
    iCollide = 1'b0; iFrameTick = 1'b0;
    check("collide_pulse", oScorePulse, 0);
    check_state("collide");
    check("collide_x0", oPipe1X, 666);
    for (int i = 0; i < 10; i++) frame();
    check("frozen_x0", oPipe1X, 666);

    // Restart from FROZEN.
    start(1'b0);
    check("restart_x0", oPipe1X, 640);
    check("restart_x2", oPipe3X, 1120);
    check("restart_score", oScore, 0);
    for (int i = 0; i < 3; i++) frame();
    iStart = 1'b1;
    @(posedge iClock); #1;
    iStart = 1'b0;
    check_state("start_in_run");
    check("start_in_run_x0", oPipe1X, 634);

    // Run to a score of 5, then reset mid-run.
    n = 0;
    while (escore < 5 && n < 2000) begin frame(); n++; end
    check("score_five", oScore, 5);
    iReset = 1'b1;
    @(posedge iClock); #1;
    iReset = 1'b0;
    model_reset();
    check_state("midrun_reset");
    check("midrun_pulse", oScorePulse, 0);
    check("midrun_lfsr", u_dut.u_lfsr.oValue, 16'hACE1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
